mat_mult_seq: RTL and testbench

Sequential, parametrised signed matrix multiplier computing C = A × B for square matrices of up to DIM×DIM elements of W bits each. It is the coprocessor's multiply engine: it accepts a runtime matrix size, uses a start/busy/done handshake, produces one result element per cycle, and reports overflow. It sits behind the instruction decoder, alongside the other matrix operation units, and shares their flattened-bus element packing.

---
 rtl/mat_pkg.sv | 32 +++
 rtl/mat_dot_row.sv | 24 ++
 rtl/mat_mult_seq.sv | 139 +++++++++++++
 tb/tb_mat_mult_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix operation units: FSM states, accumulator sizing,
// flattened-bus element indexing and signed saturation limits.
package mat_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Accumulator width that holds a DIM-term sum of W x W signed products.
    function automatic int acc_w(input int w, input int dim);
        int lg;
        lg = 0;
        while ((1 << lg) < dim) lg++;
        return 2 * w + lg;
    endfunction

    // Element (0,0) sits in the MSBs of the flattened bus.
    function automatic int elem_lsb(input int r, input int c, input int dim, input int w);
        return w * (dim * dim - 1 - (r * dim + c));
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/mat_dot_row.sv
// Combinational signed dot product of DIM lane pairs; disabled lanes contribute nothing.
module mat_dot_row
    import mat_pkg::*;
#(
    parameter int DIM   = 5,
    parameter int W     = 8,
    parameter int ACC_W = acc_w(W, DIM)
) (
    input  logic [DIM*W-1:0]        a_row,
    input  logic [DIM*W-1:0]        b_col,
    input  logic [DIM-1:0]          lane_en,
    output logic signed [ACC_W-1:0] dot
);

    always_comb begin
        dot = '0;
        for (int k = 0; k < DIM; k++) begin
            if (lane_en[k]) begin
                dot = dot + ACC_W'($signed(a_row[k*W +: W])) * ACC_W'($signed(b_col[k*W +: W]));
            end
        end
    end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential signed matrix multiplier, one result element per cycle.
// Define MAT_SATURATE_EN to clamp overflowing elements instead of wrapping them.
module mat_mult_seq
    import mat_pkg::*;
#(
    parameter int DIM = 5,
    parameter int W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(DIM+1)-1:0]   mat_size,
    input  logic [DIM*DIM*W-1:0]       lin,
    input  logic [DIM*DIM*W-1:0]       col,
    output logic [DIM*DIM*W-1:0]       n_out,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf
);

    localparam int SW    = $clog2(DIM + 1);
    localparam int N     = DIM * DIM * W;
    localparam int ACC_W = acc_w(W, DIM);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(W));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(W));

    state_t                  state;
    logic [N-1:0]            a_reg;
    logic [N-1:0]            b_reg;
    logic [SW-1:0]           s_reg;
    logic [SW-1:0]           s_eff;
    logic [SW-1:0]           row_idx;
    logic [SW-1:0]           col_idx;
    logic [DIM*W-1:0]        a_row;
    logic [DIM*W-1:0]        b_col;
    logic [DIM-1:0]          lane_en;
    logic signed [ACC_W-1:0] dot;
    logic [W-1:0]            elem_val;
    logic                    elem_ovf;
    logic                    last_col;
    logic                    last_row;

    // Out-of-range sizes (0 or above DIM) select the full matrix.
    assign s_eff    = (mat_size == '0 || mat_size > SW'(DIM)) ? SW'(DIM) : mat_size;
    assign last_col = (col_idx == s_reg - SW'(1));
    assign last_row = (row_idx == s_reg - SW'(1));

    always_comb begin
        a_row   = '0;
        b_col   = '0;
        lane_en = '0;
        for (int k = 0; k < DIM; k++) begin
            a_row[k*W +: W] = a_reg[elem_lsb(int'(row_idx), k, DIM, W) +: W];
            b_col[k*W +: W] = b_reg[elem_lsb(k, int'(col_idx), DIM, W) +: W];
            lane_en[k]      = (k < int'(s_reg));
        end
    end

    mat_dot_row #(
        .DIM   (DIM),
        .W     (W),
        .ACC_W (ACC_W)
    ) u_dot_row (
        .a_row   (a_row),
        .b_col   (b_col),
        .lane_en (lane_en),
        .dot     (dot)
    );

    always_comb begin
        elem_ovf = (dot > MAX_V) || (dot < MIN_V);
`ifdef MAT_SATURATE_EN
        if (dot > MAX_V) begin
            elem_val = MAX_V[W-1:0];
        end else if (dot < MIN_V) begin
            elem_val = MIN_V[W-1:0];
        end else begin
            elem_val = dot[W-1:0];
        end
`else
        elem_val = dot[W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            s_reg   <= '0;
            row_idx <= '0;
            col_idx <= '0;
            n_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= lin;
                        b_reg   <= col;
                        s_reg   <= s_eff;
                        row_idx <= '0;
                        col_idx <= '0;
                        n_out   <= '0;
                        ovf     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    n_out[elem_lsb(int'(row_idx), int'(col_idx), DIM, W) +: W] <= elem_val;
                    ovf <= ovf | elem_ovf;
                    if (last_col) begin
                        col_idx <= '0;
                        if (last_row) begin
                            state <= DONE;
                        end else begin
                            row_idx <= row_idx + SW'(1);
                        end
                    end else begin
                        col_idx <= col_idx + SW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq against an integer-matrix reference model.
module tb_mat_mult_seq;

    localparam int DIM = 5;
    localparam int W   = 8;
    localparam int SW  = $clog2(DIM + 1);
    localparam int N   = DIM * DIM * W;

    typedef int mat_t [DIM][DIM];

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] mat_size;
    logic [N-1:0]  lin;
    logic [N-1:0]  col;
    logic [N-1:0]  n_out;
    logic          busy;
    logic          done;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mat_mult_seq #(
        .DIM (DIM),
        .W   (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mat_size (mat_size),
        .lin      (lin),
        .col      (col),
        .n_out    (n_out),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    // Packs an integer matrix onto the flattened bus, (0,0) in the MSBs, low W bits kept.
    function automatic logic [N-1:0] pack(input mat_t m);
        logic [N-1:0] res;
        res = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                res[W*(DIM*DIM-1-(r*DIM+c)) +: W] = W'(m[r][c]);
        return res;
    endfunction

    function automatic mat_t fill(input int v);
        mat_t m;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m[r][c] = v;
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m[r][c] = int'($urandom_range(255)) - 128;
        return m;
    endfunction

    function automatic int eff_size(input int sz);
        return (sz == 0 || sz > DIM) ? DIM : sz;
    endfunction

    // Reference: plain integer matrix product over the active S x S block.
    function automatic void model(input mat_t a, input mat_t b, input int sz,
                                  output logic [N-1:0] res, output logic ov);
        mat_t c;
        int   s;
        int   dot;
        s  = eff_size(sz);
        ov = 1'b0;
        c  = fill(0);
        for (int r = 0; r < s; r++) begin
            for (int j = 0; j < s; j++) begin
                dot = 0;
                for (int k = 0; k < s; k++) dot += a[r][k] * b[k][j];
                if (dot > 127 || dot < -128) ov = 1'b1;
`ifdef MAT_SATURATE_EN
                if (dot > 127) dot = 127;
                if (dot < -128) dot = -128;
`endif
                c[r][j] = dot;
            end
        end
        res = pack(c);
    endfunction

    task automatic launch(input mat_t a, input mat_t b, input int sz);
        lin      = pack(a);
        col      = pack(b);
        mat_size = SW'(sz);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Counts cycles from the start edge until done is seen; bounded.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 1000) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mat_size = '0; lin = '0; col = '0;
        #12;
        checks++; if (n_out !== '0) begin errors++; $display("[TB] FAIL reset_n_out: got %h expected 0", n_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        mat_t a, b;
        logic [N-1:0] er;
        logic eo;
        int lat, bc;
        a = fill(0);
        for (int r = 0; r < DIM; r++) a[r][r] = 1;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) b[r][c] = r * DIM + c + 1;
        model(a, b, 5, er, eo);
        launch(a, b, 5);
        wait_done(lat, bc);
        checks++; if (lat !== 26) begin errors++; $display("[TB] FAIL identity_latency: got %0d expected 26", lat); end
        checks++; if (bc !== 26) begin errors++; $display("[TB] FAIL identity_busy_cycles: got %0d expected 26", bc); end
        checks++; if (n_out !== pack(b)) begin errors++; $display("[TB] FAIL identity_result: got %h expected %h", n_out, pack(b)); end
        checks++; if (n_out !== er) begin errors++; $display("[TB] FAIL identity_model: got %h expected %h", n_out, er); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL identity_ovf: got %b expected 0", ovf); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL identity_done_pulse: got %b expected 0", done); end
        checks++; if (n_out !== pack(b)) begin errors++; $display("[TB] FAIL identity_hold: got %h expected %h", n_out, pack(b)); end
    endtask

    task automatic test_overflow();
        int av [3] = '{127, -128, -128};
        int bv [3] = '{127, 1, -128};
`ifdef MAT_SATURATE_EN
        int ev [3] = '{127, 128, 127};
`else
        int ev [3] = '{5, 128, 0};
`endif
        logic [N-1:0] er;
        logic eo;
        int lat, bc;
        for (int t = 0; t < 3; t++) begin
            model(fill(av[t]), fill(bv[t]), 5, er, eo);
            launch(fill(av[t]), fill(bv[t]), 5);
            wait_done(lat, bc);
            checks++; if (n_out !== pack(fill(ev[t]))) begin errors++; $display("[TB] FAIL ovf_case%0d_value: got %h expected %h", t, n_out, pack(fill(ev[t]))); end
            checks++; if (n_out !== er) begin errors++; $display("[TB] FAIL ovf_case%0d_model: got %h expected %h", t, n_out, er); end
            checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_case%0d_flag: got %b expected 1", t, ovf); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_size();
        int sizes [3] = '{3, 0, 7};
        mat_t em;
        int s, lat, bc;
        for (int t = 0; t < 3; t++) begin
            s  = eff_size(sizes[t]);
            em = fill(0);
            for (int r = 0; r < s; r++)
                for (int c = 0; c < s; c++) em[r][c] = 4 * s;
            launch(fill(2), fill(2), sizes[t]);
            wait_done(lat, bc);
            checks++; if (lat !== s * s + 1) begin errors++; $display("[TB] FAIL size%0d_latency: got %0d expected %0d", sizes[t], lat, s * s + 1); end
            checks++; if (n_out !== pack(em)) begin errors++; $display("[TB] FAIL size%0d_result: got %h expected %h", sizes[t], n_out, pack(em)); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL size%0d_ovf: got %b expected 0", sizes[t], ovf); end
            @(posedge clk); #1;
        end
    endtask

    // Random operands and sizes; inputs are scrambled while the operation runs.
    task automatic test_random();
        int sizes [5] = '{1, 2, 4, 5, 3};
        mat_t a, b;
        logic [N-1:0] er;
        logic eo;
        int s, lat, bc;
        for (int t = 0; t < 5; t++) begin
            a = rand_mat();
            b = rand_mat();
            if (t == 4) s = int'($urandom_range(DIM, 1)); else s = sizes[t];
            model(a, b, s, er, eo);
            launch(a, b, s);
            lin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            col = ~lin;
            wait_done(lat, bc);
            checks++; if (lat !== s * s + 1) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", t, lat, s * s + 1); end
            checks++; if (n_out !== er) begin errors++; $display("[TB] FAIL rand%0d_result: got %h expected %h", t, n_out, er); end
            checks++; if (ovf !== eo) begin errors++; $display("[TB] FAIL rand%0d_ovf: got %b expected %b", t, ovf, eo); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_ignored();
        mat_t a, b;
        logic [N-1:0] er;
        logic eo;
        int lat;
        a = rand_mat();
        b = rand_mat();
        model(a, b, 5, er, eo);
        launch(a, b, 5);
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            if (lat == 5) begin
                lin   = pack(fill(7));
                col   = pack(fill(-3));
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++; if (lat !== 26) begin errors++; $display("[TB] FAIL restart_latency: got %0d expected 26", lat); end
        checks++; if (n_out !== er) begin errors++; $display("[TB] FAIL restart_result: got %h expected %h", n_out, er); end
        checks++; if (ovf !== eo) begin errors++; $display("[TB] FAIL restart_ovf: got %b expected %b", ovf, eo); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        mat_t a, b;
        logic [N-1:0] er;
        logic eo;
        int lat, bc;
        launch(fill(127), fill(127), 5);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (n_out !== '0) begin errors++; $display("[TB] FAIL midrst_n_out: got %h expected 0", n_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ovf: got %b expected 0", ovf); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        a = rand_mat();
        b = rand_mat();
        model(a, b, 4, er, eo);
        launch(a, b, 4);
        wait_done(lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected 17", lat); end
        checks++; if (n_out !== er) begin errors++; $display("[TB] FAIL midrst_result: got %h expected %h", n_out, er); end
        checks++; if (ovf !== eo) begin errors++; $display("[TB] FAIL midrst_ovf_after: got %b expected %b", ovf, eo); end
        @(posedge clk); #1;
    endtask

    // Second start is issued in the very cycle done is high.
    task automatic test_back_to_back();
        mat_t a1, b1, a2, b2;
        logic [N-1:0] er1, er2;
        logic eo1, eo2;
        int lat, bc;
        a1 = rand_mat(); b1 = rand_mat();
        a2 = rand_mat(); b2 = rand_mat();
        model(a1, b1, 3, er1, eo1);
        model(a2, b2, 2, er2, eo2);
        launch(a1, b1, 3);
        wait_done(lat, bc);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected 10", lat); end
        checks++; if (n_out !== er1) begin errors++; $display("[TB] FAIL b2b_first_result: got %h expected %h", n_out, er1); end
        launch(a2, b2, 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_busy: got %b expected 1", busy); end
        wait_done(lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 5", lat); end
        checks++; if (n_out !== er2) begin errors++; $display("[TB] FAIL b2b_second_result: got %h expected %h", n_out, er2); end
        checks++; if (ovf !== eo2) begin errors++; $display("[TB] FAIL b2b_second_ovf: got %b expected %b", ovf, eo2); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_overflow();
        test_size();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
